mod_updown_counter: RTL and testbench
=====================================

// Module: mod_updown_counter
// PURPOSE
//  Parametrised modulo-N up/down counter: the generic time-digit stage for the min/sec timer and stopwatch.
//  Accepts a count pulse from the lower stage and emits a same-cycle terminal pulse to the next stage.
//  Holds its count in a register and presents registered binary and two-digit decimal outputs to the FND path.
//  Adds sync clear, parallel load, down counting and pause.
// PARAMETERS
//  MODULUS  60  count range 0..MODULUS-1; legal 2..100
//  OUT_W    8   width of val / load_val; must satisfy 2**OUT_W >= MODULUS
// PORTS
//  clk       in   1      system clock, rising edge
//  rst       in   1      asynchronous reset, active-high
//  en        in   1      stage enable; 0 freezes count and forces tc=0 (pause)
//  clr       in   1      synchronous clear to 0
//  load      in   1      synchronous parallel load of load_val
//  load_val  in   OUT_W  value for load
//  inc       in   1      count-up pulse (carry from lower stage)
//  dec       in   1      count-down pulse (borrow from lower stage)
//  val       out  OUT_W  current count, binary
//  tens      out  4      val / 10, BCD
//  ones      out  4      val % 10, BCD
//  tc        out  1      terminal pulse to next stage (combinational)
// BEHAVIOUR
//  - Reset is asynchronous and active-high. Under rst: val=0, tens=0, ones=0. tc is 0 while rst is high.
//  - All state updates on the rising clk edge. Priority: rst > clr > load > count.
//  - clr=1: val <- 0 on the next edge, regardless of en.
//  - load=1: val <- load_val on the next edge, regardless of en.
//    If load_val >= MODULUS, val <- MODULUS-1 (saturate, never out of range).
//  - Count step applies only when en=1, clr=0 and load=0:
//    - inc=1, dec=0: val <- (val==MODULUS-1) ? 0 : val+1
//    - dec=1, inc=0: val <- (val==0) ? MODULUS-1 : val-1
//    - inc=dec=1, or inc=dec=0: val holds. tc=0.
//  - tc = en & ~clr & ~load & ~rst & ( (inc&~dec&val==MODULUS-1) | (dec&~inc&val==0) ).
//    - tc is asserted in the same cycle as the wrapping step, so it can be chained into the next stage's inc or dec.
//    - tc is a one-cycle pulse per wrap event.
//  - Latency: one clk edge from a qualified inc/dec/clr/load to the new val.
//    tens and ones change on the same edge as val; there is no extra cycle of skew.
//  - tens/ones are registered, computed from the next-state value (not from val).
//  - Invariant: val is always < MODULUS. A stray out-of-range val (e.g. from an SEU) is forced to 0 on the next edge, even if en=0.
//  - Reset asserted mid-count: outputs go to 0 immediately (async).
//    The first count step occurs on the first qualified edge after rst deasserts.
// STRUCTURE
//  - Shared header timer_defs.vh holds:
//    - localparams SEC_MOD=60, MIN_MOD=60, HOUR_MOD=24, MSEC_MOD=100
//    - BCD_W=4
//  - Sub-module bin2dec2: combinational OUT_W -> {tens, ones}, valid for 0..99.
//    It is instantiated once, on the next-state value.
//  - One always block for state (val, tens, ones). Next-state logic and tc are combinational assigns.
// TESTING
//  - Reset: MODULUS=60. Assert rst mid-count at val=37 -> val/tens/ones=0 asynchronously and tc=0; holds at 0 after release until inc.
//  - Up wrap: val=58, en=1, 2 inc pulses -> val 59 then 0; tc=1 only in the cycle val==59 & inc; tens/ones=5,9 then 0,0.
//  - Down wrap: val=0, dec=1 -> tc=1 same cycle, next val=59, tens=5, ones=9.
//  - Priority: at val=20, clr=1, load=1, load_val=45, inc=1 in one cycle -> val=0, tc=0. Repeat with clr=0 -> val=45.
//  - Load saturate and pause:
//    - load_val=75 -> val=59.
//    - en=0 with inc pulses -> val stays 59, tc=0.
//    - inc=dec=1 with en=1 -> val holds.
//  - Cascade: two instances (sec, min). sec.tc drives min.inc; 3600 inc pulses into sec -> min and sec both back to 0, exactly 60 min steps, no double counts.

Source files
------------

// File: rtl/mod_updown_counter_pkg.sv
// Shared timer constants and digit payload type for the time-digit counter stages.
package mod_updown_counter_pkg;

  localparam int unsigned SEC_MOD  = 60;
  localparam int unsigned MIN_MOD  = 60;
  localparam int unsigned HOUR_MOD = 24;
  localparam int unsigned MSEC_MOD = 100;
  localparam int unsigned BCD_W    = 4;

  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } bcd2_t;

endpackage

// File: rtl/mod_updown_counter_bin2dec2.sv
// Combinational binary to two-digit BCD split, valid for inputs 0..99.
module mod_updown_counter_bin2dec2
  import mod_updown_counter_pkg::*;
#(
  parameter int unsigned OUT_W = 8
) (
  input  logic [OUT_W-1:0] bin,
  output bcd2_t            dig_c
);

  logic [31:0] bin_w;

  // Constant-divisor split; the inputs are bounded below 100 by the caller.
  always_comb begin
    bin_w      = 32'(bin);
    dig_c.tens = BCD_W'(bin_w / 32'd10);
    dig_c.ones = BCD_W'(bin_w % 32'd10);
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down time-digit stage with clear, load, pause and a same-cycle terminal pulse.
module mod_updown_counter
  import mod_updown_counter_pkg::*;
#(
  parameter int unsigned MODULUS = 60,
  parameter int unsigned OUT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [OUT_W-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic [OUT_W-1:0] val,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones,
  output logic             tc
);

  localparam logic [OUT_W-1:0] MAX_VAL = OUT_W'(MODULUS - 1);

  logic [OUT_W-1:0] val_nxt;
  logic [OUT_W-1:0] load_sat;
  logic             in_range;
  logic             at_max;
  logic             at_zero;
  logic             step_up;
  logic             step_dn;
  bcd2_t            dig_nxt;

  // Range checks are done at 32 bits so MODULUS == 2**OUT_W stays correct.
  always_comb begin
    in_range = (32'(val) < MODULUS);
    load_sat = (32'(load_val) >= MODULUS) ? MAX_VAL : load_val;
    at_max   = (val == MAX_VAL);
    at_zero  = (val == '0);
    step_up  = en & inc & ~dec;
    step_dn  = en & dec & ~inc;
  end

  // Priority: clr > load > out-of-range recovery > count step.
  always_comb begin
    val_nxt = val;
    if (clr) begin
      val_nxt = '0;
    end else if (load) begin
      val_nxt = load_sat;
    end else if (!in_range) begin
      val_nxt = '0;
    end else if (step_up) begin
      val_nxt = at_max ? '0 : val + OUT_W'(1);
    end else if (step_dn) begin
      val_nxt = at_zero ? MAX_VAL : val - OUT_W'(1);
    end
  end

  assign tc = ~rst & ~clr & ~load & ((step_up & at_max) | (step_dn & at_zero));

  // Digits come from the next-state value so they land on the same edge as val.
  mod_updown_counter_bin2dec2 #(
    .OUT_W (OUT_W)
  ) u_bin2dec2 (
    .bin   (val_nxt),
    .dig_c (dig_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val  <= '0;
      tens <= '0;
      ones <= '0;
    end else begin
      val  <= val_nxt;
      tens <= dig_nxt.tens;
      ones <= dig_nxt.ones;
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench: directed vector table, reset/cascade sequences and a randomized reference model.
module tb_mod_updown_counter;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en, clr, load, inc, dec;
  logic [W-1:0] load_val;
  logic [W-1:0] val;
  logic [3:0]   tens, ones;
  logic         tc;

  logic         c_inc;
  logic [W-1:0] sec_val, min_val;
  logic [3:0]   sec_tens, sec_ones, min_tens, min_ones;
  logic         sec_tc, min_tc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_updown_counter #(.MODULUS(60), .OUT_W(W)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .inc(inc), .dec(dec), .val(val), .tens(tens), .ones(ones), .tc(tc)
  );

  mod_updown_counter #(.MODULUS(60), .OUT_W(W)) u_sec (
    .clk(clk), .rst(rst), .en(1'b1), .clr(1'b0), .load(1'b0), .load_val('0),
    .inc(c_inc), .dec(1'b0), .val(sec_val), .tens(sec_tens), .ones(sec_ones), .tc(sec_tc)
  );

  mod_updown_counter #(.MODULUS(60), .OUT_W(W)) u_min (
    .clk(clk), .rst(rst), .en(1'b1), .clr(1'b0), .load(1'b0), .load_val('0),
    .inc(sec_tc), .dec(1'b0), .val(min_val), .tens(min_tens), .ones(min_ones), .tc(min_tc)
  );

  typedef struct {
    bit       clr;
    bit       load;
    bit [7:0] lv;
    bit       en;
    bit       inc;
    bit       dec;
    int       exp_tc;
    int       exp_val;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit c, input bit l, input bit [7:0] lv,
                       input bit e, input bit i, input bit d);
    clr = c; load = l; load_val = lv; en = e; inc = i; dec = d;
  endtask

  // Check tc before the edge, then val and digits just after it.
  task automatic step_chk(input string nm, input int exp_tc, input int exp_val);
    #1;
    chk({nm, "_tc"}, int'(tc), exp_tc);
    @(posedge clk);
    #1;
    chk({nm, "_val"}, int'(val), exp_val);
    chk({nm, "_tens"}, int'(tens), exp_val / 10);
    chk({nm, "_ones"}, int'(ones), exp_val % 10);
  endtask

  function automatic vec_t mk(bit c, bit l, bit [7:0] lv, bit e, bit i, bit d, int t, int v);
    vec_t r;
    r.clr = c; r.load = l; r.lv = lv; r.en = e; r.inc = i; r.dec = d;
    r.exp_tc = t; r.exp_val = v;
    return r;
  endfunction

  initial begin
    int m;
    int exp_tc;
    int min_steps;
    int min_wraps;
    bit c, l, e, i, d;
    bit [7:0] lv;

    rst = 1'b1;
    c_inc = 1'b0;
    drive(0, 0, 8'd0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_val", int'(val), 0);
    chk("rst_tens", int'(tens), 0);
    chk("rst_ones", int'(ones), 0);
    chk("rst_tc", int'(tc), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    //           clr load lv   en inc dec tc val
    vecs.push_back(mk(0, 1,  58, 0, 0, 0, 0, 58));
    vecs.push_back(mk(0, 0,   0, 1, 1, 0, 0, 59));
    vecs.push_back(mk(0, 0,   0, 1, 1, 0, 1,  0));
    vecs.push_back(mk(0, 0,   0, 1, 0, 1, 1, 59));
    vecs.push_back(mk(0, 0,   0, 1, 0, 1, 0, 58));
    vecs.push_back(mk(0, 1,  20, 1, 0, 0, 0, 20));
    vecs.push_back(mk(1, 1,  45, 1, 1, 0, 0,  0));
    vecs.push_back(mk(0, 1,  45, 1, 1, 0, 0, 45));
    vecs.push_back(mk(0, 1,  75, 1, 0, 0, 0, 59));
    vecs.push_back(mk(0, 0,   0, 0, 1, 0, 0, 59));
    vecs.push_back(mk(0, 0,   0, 0, 1, 0, 0, 59));
    vecs.push_back(mk(0, 0,   0, 1, 1, 1, 0, 59));
    vecs.push_back(mk(1, 0,   0, 0, 0, 0, 0,  0));
    vecs.push_back(mk(0, 0,   0, 0, 0, 1, 0,  0));
    vecs.push_back(mk(0, 1,  99, 0, 0, 0, 0, 59));
    vecs.push_back(mk(0, 1,   0, 1, 0, 1, 0,  0));
    vecs.push_back(mk(0, 1, 255, 0, 0, 0, 0, 59));
    vecs.push_back(mk(0, 1,  60, 1, 1, 0, 0, 59));
    vecs.push_back(mk(0, 1,  59, 1, 0, 1, 0, 59));

    foreach (vecs[k]) begin
      drive(vecs[k].clr, vecs[k].load, vecs[k].lv, vecs[k].en, vecs[k].inc, vecs[k].dec);
      step_chk($sformatf("vec%0d", k), vecs[k].exp_tc, vecs[k].exp_val);
    end

    // Asynchronous reset in the middle of counting.
    drive(0, 1, 8'd36, 1, 0, 0);
    step_chk("pre_rst_load", 0, 36);
    drive(0, 0, 8'd0, 1, 1, 0);
    step_chk("pre_rst_inc", 0, 37);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_val", int'(val), 0);
    chk("async_rst_tens", int'(tens), 0);
    chk("async_rst_ones", int'(ones), 0);
    chk("async_rst_tc", int'(tc), 0);
    @(posedge clk);
    #1;
    chk("rst_hold_val", int'(val), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 8'd0, 1, 0, 0);
    step_chk("post_rst_idle0", 0, 0);
    step_chk("post_rst_idle1", 0, 0);
    drive(0, 0, 8'd0, 1, 1, 0);
    step_chk("post_rst_inc", 0, 1);

    // Randomized traffic against an arithmetic reference.
    drive(1, 0, 8'd0, 0, 0, 0);
    step_chk("rand_init", 0, 0);
    m = 0;
    for (int n = 0; n < 2000; n++) begin
      c  = ($urandom_range(0, 19) == 0);
      l  = ($urandom_range(0, 9) == 0);
      lv = 8'($urandom_range(0, 255));
      e  = ($urandom_range(0, 3) != 0);
      i  = 1'($urandom);
      d  = 1'($urandom);
      exp_tc = (!c && !l && e && ((i && !d && m == 59) || (d && !i && m == 0))) ? 1 : 0;
      if (c)                m = 0;
      else if (l)           m = (int'(lv) >= 60) ? 59 : int'(lv);
      else if (e && i && !d) m = (m + 1) % 60;
      else if (e && d && !i) m = (m + 59) % 60;
      drive(c, l, lv, e, i, d);
      step_chk("rand", exp_tc, m);
    end
    drive(0, 0, 8'd0, 0, 0, 0);

    // Seconds stage carries into minutes stage.
    min_steps = 0;
    min_wraps = 0;
    for (int p = 1; p <= 3600; p++) begin
      c_inc = 1'b1;
      #1;
      if (sec_tc) min_steps++;
      if (min_tc) min_wraps++;
      @(posedge clk);
      #1;
      if (p % 60 == 0) chk("casc_min_progress", int'(min_val), (p / 60) % 60);
      if (p == 1800) chk("casc_sec_mid", int'(sec_val), 0);
    end
    c_inc = 1'b0;
    chk("casc_min_steps", min_steps, 60);
    chk("casc_min_wraps", min_wraps, 1);
    chk("casc_sec_val", int'(sec_val), 0);
    chk("casc_min_val", int'(min_val), 0);
    chk("casc_min_digits", int'({min_tens, min_ones, sec_tens, sec_ones}), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
